mod_147_tx_cmd_sched: RTL

//   Transmit-side command scheduler for the Clause 147 PCS, on the far side of the link status
//   (pcs_status) machine. Arbitrates the 2-bit tx_cmd symbol slot between MAC data (tx_en),

---
 rtl/mod_147_tx_cmd_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mod_147_tx_cmd_sched.sv
// Clause 147 transmit command scheduler: arbitrates the tx_cmd slot between MAC data, PLCA
// BEACON/COMMIT and an internally timed HEARTBEAT; also owns the link_hold_timer.
module mod_147_tx_cmd_sched #(
  parameter int unsigned HB_PERIOD = 16,
  parameter int unsigned HB_LEN    = 4,
  parameter int unsigned HOLD_CNT  = 64,
  parameter int unsigned CW        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hb_enable,
  input  logic       tx_en,
  input  logic       plca_beacon_req,
  input  logic       plca_commit_req,
  input  logic       hold_start,
  output logic [1:0] tx_cmd,
  output logic       hb_active,
  output logic [7:0] hb_count,
  output logic       link_hold_timer_done
);

  localparam logic [1:0]    CmdBeacon = 2'b00;
  localparam logic [1:0]    CmdCommit = 2'b01;
  localparam logic [1:0]    CmdHb     = 2'b10;
  localparam logic [1:0]    CmdNone   = 2'b11;
  localparam logic [CW-1:0] PeriodLast = CW'(HB_PERIOD - 1);
  localparam logic [CW-1:0] LenLast    = CW'(HB_LEN - 1);
  localparam logic [CW-1:0] HoldLoad   = CW'(HOLD_CNT);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   period_q, period_d;
  logic [CW-1:0]   len_q, len_d;
  logic            hb_done;
  logic            busy;
  logic [1:0]      cmd_d;
  logic [1:0]      cmd_q;
  logic            hb_active_q;
  logic [7:0]      hb_count_q;
  logic [CW-1:0]   hold_q;
  logic            running_q;
  logic            done_q;

  assign busy = tx_en | plca_beacon_req | plca_commit_req;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    len_d    = len_q;
    hb_done  = 1'b0;
    if (!hb_enable) begin
      state_d  = StIdle;
      period_d = '0;
      len_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StWait;
          period_d = '0;
        end
        StWait: begin
          // Any activity restarts the idle interval, so a heartbeat never preempts.
          if (busy) begin
            period_d = '0;
          end else if (period_q == PeriodLast) begin
            state_d = StSend;
            len_d   = '0;
          end else begin
            period_d = period_q + CW'(1);
          end
        end
        StSend: begin
          if (busy) begin
            state_d  = StWait;
            period_d = '0;
          end else if (len_q == LenLast) begin
            state_d  = StWait;
            period_d = '0;
            hb_done  = 1'b1;
          end else begin
            len_d = len_q + CW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cmd_d = CmdNone;
    if (tx_en) begin
      cmd_d = CmdNone;
    end else if (plca_beacon_req) begin
      cmd_d = CmdBeacon;
    end else if (plca_commit_req) begin
      cmd_d = CmdCommit;
    end else if (state_d == StSend) begin
      cmd_d = CmdHb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      period_q    <= '0;
      len_q       <= '0;
      cmd_q       <= CmdNone;
      hb_active_q <= 1'b0;
      hb_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      hb_active_q <= (state_d == StSend);
      if (hb_done && (hb_count_q != 8'hFF)) begin
        hb_count_q <= hb_count_q + 8'd1;
      end
    end
  end

  // A start pulse always wins, including on the cycle the count would expire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (hold_start) begin
      hold_q    <= HoldLoad;
      running_q <= 1'b1;
      done_q    <= 1'b0;
    end else if (running_q) begin
      if (hold_q == CW'(1)) begin
        hold_q    <= '0;
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end else begin
        hold_q <= hold_q - CW'(1);
      end
    end
  end

  assign tx_cmd               = cmd_q;
  assign hb_active            = hb_active_q;
  assign hb_count             = hb_count_q;
  assign link_hold_timer_done = done_q;

endmodule
